// File: rtl/pc_sequencer_if.sv
// Instruction- and data-memory handshake bundle between the sequencer and the memories.
// The master side is the sequencer; the slave side is the memory system.
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        output dmem_req,
        input  imem_ready,
        input  imem_rdata,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        input  dmem_req,
        output imem_ready,
        output imem_rdata,
        output dmem_ready
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, drives memory handshakes, computes next PC
// and issues the register-file write strobe once per completed instruction.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// RESET   | idle after reset release, moves to FETCH on the next edge
// FETCH   | imem_req high, waits for imem_ready, latches the instruction
// DECODE  | one cycle for the decoder to settle on the latched instruction
// EXECUTE | samples decode flags, registers next PC
// MEM     | dmem_req high, waits for dmem_ready (loads/stores only)
// WB      | rf_we strobe, PC update, or halt on a misaligned target
// HALT    | absorbing; only reset leaves it
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_sequencer_if.master       bus,
    output logic [31:0]          o_instr,
    input  logic                 i_is_branch,
    input  logic                 i_branch_taken,
    input  logic                 i_is_jump,
    input  logic                 i_is_jalr,
    input  logic                 i_is_load,
    input  logic                 i_is_store,
    input  logic                 i_rd_writes,
    input  logic [31:0]          i_immed,
    input  logic [31:0]          i_rs1_data,
    output logic [31:0]          o_pc,
    output logic [31:0]          o_pc_plus4,
    output logic                 o_rf_we,
    output logic                 o_halted,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_next_pc;
    logic        r_halted;
    logic        r_wb_en;
    logic [31:0] w_target;
    logic        w_aligned;

    always_comb begin
        w_target = r_pc + 32'd4;
        if (i_is_jalr)
            w_target = (i_rs1_data + i_immed) & ~32'h1;
        else if (i_is_jump || (i_is_branch && i_branch_taken))
            w_target = r_pc + i_immed;
    end

    assign w_aligned = (r_next_pc[1:0] == 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RESET:   w_state_nxt = S_FETCH;
            S_FETCH:   if (bus.imem_ready) w_state_nxt = S_DECODE;
            S_DECODE:  w_state_nxt = S_EXECUTE;
            S_EXECUTE: w_state_nxt = (i_is_load || i_is_store) ? S_MEM : S_WB;
            S_MEM:     if (bus.dmem_ready) w_state_nxt = S_WB;
            S_WB:      w_state_nxt = w_aligned ? S_FETCH : S_HALT;
            S_HALT:    w_state_nxt = S_HALT;
            default:   w_state_nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RESET;
            r_pc      <= RESET_PC;
            r_instr   <= '0;
            r_next_pc <= '0;
            r_halted  <= 1'b0;
            r_wb_en   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_FETCH && bus.imem_ready)
                r_instr <= bus.imem_rdata;
            // Write-enable is captured with the other decode flags so WB does not depend on them.
            if (r_state == S_EXECUTE) begin
                r_next_pc <= w_target;
                r_wb_en   <= i_rd_writes & ~i_is_store;
            end
            if (r_state == S_WB) begin
                if (w_aligned)
                    r_pc <= r_next_pc;
                else
                    r_halted <= 1'b1;
            end
        end
    end

    assign bus.imem_req  = (r_state == S_FETCH);
    assign bus.imem_addr = r_pc;
    assign bus.dmem_req  = (r_state == S_MEM);
    assign o_rf_we       = (r_state == S_WB) && r_wb_en && w_aligned;
    assign o_instr       = r_instr;
    assign o_pc          = r_pc;
    assign o_pc_plus4    = r_pc + 32'd4;
    assign o_halted      = r_halted;
    assign o_state       = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized instructions
// compared against a per-instruction model of PC, cycle count and write strobe.
module tb_pc_sequencer;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [2:0] ST_RESET = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                           ST_EXECUTE = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] o_instr, o_pc, o_pc_plus4;
    logic        i_is_branch, i_branch_taken, i_is_jump, i_is_jalr, i_is_load, i_is_store, i_rd_writes;
    logic [31:0] i_immed, i_rs1_data;
    logic        o_rf_we, o_halted;
    logic [2:0]  o_state;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_pc;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master),
        .o_instr(o_instr),
        .i_is_branch(i_is_branch), .i_branch_taken(i_branch_taken), .i_is_jump(i_is_jump),
        .i_is_jalr(i_is_jalr), .i_is_load(i_is_load), .i_is_store(i_is_store),
        .i_rd_writes(i_rd_writes), .i_immed(i_immed), .i_rs1_data(i_rs1_data),
        .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_rf_we(o_rf_we), .o_halted(o_halted),
        .o_state(o_state)
    );

    always #5 clk = ~clk;

    // Runs one instruction starting at a negedge where FETCH is expected; ends at the negedge after WB.
    task automatic do_instr(input bit br, input bit tk, input bit jp, input bit jr,
                            input bit ld, input bit st, input bit rdw,
                            input logic [31:0] imm, input logic [31:0] rs1,
                            input int iwait, input int dwait, input string nm);
        logic [31:0] tgt, rdata;
        logic [2:0]  es, end_st;
        bit          mem, mis, exp_we;
        int          n;
        rdata = $urandom;
        mem = ld | st;
        if (jr)                  tgt = (rs1 + imm) & ~32'h1;
        else if (jp || (br && tk)) tgt = m_pc + imm;
        else                     tgt = m_pc + 32'd4;
        mis = (tgt[1:0] != 2'b00);
        n = 4 + iwait + (mem ? 1 + dwait : 0);
        i_is_branch = br; i_branch_taken = tk; i_is_jump = jp; i_is_jalr = jr;
        i_is_load = ld; i_is_store = st; i_rd_writes = rdw;
        i_immed = imm; i_rs1_data = rs1; bus.imem_rdata = rdata;
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge clk);
            if (c <= iwait)          es = ST_FETCH;
            else if (c == iwait + 1) es = ST_DECODE;
            else if (c == iwait + 2) es = ST_EXECUTE;
            else if (c == n - 1)     es = ST_WB;
            else                     es = ST_MEM;
            exp_we = (es == ST_WB) && rdw && !st && !mis;
            vectors++;
            if (o_state !== es) begin
                miscompares++;
                $display("FAIL %s state cycle %0d: got %0d expected %0d", nm, c, o_state, es);
            end
            vectors++;
            if (o_pc !== m_pc || bus.imem_addr !== m_pc || o_pc_plus4 !== m_pc + 32'd4) begin
                miscompares++;
                $display("FAIL %s pc cycle %0d: got pc=%h addr=%h plus4=%h expected pc=%h",
                         nm, c, o_pc, bus.imem_addr, o_pc_plus4, m_pc);
            end
            vectors++;
            if (bus.imem_req !== (es == ST_FETCH) || bus.dmem_req !== (es == ST_MEM)) begin
                miscompares++;
                $display("FAIL %s req cycle %0d: got imem_req=%b dmem_req=%b expected %b %b",
                         nm, c, bus.imem_req, bus.dmem_req, es == ST_FETCH, es == ST_MEM);
            end
            vectors++;
            if (o_rf_we !== exp_we) begin
                miscompares++;
                $display("FAIL %s rf_we cycle %0d: got %b expected %b", nm, c, o_rf_we, exp_we);
            end
            if (es == ST_DECODE) begin
                vectors++;
                if (o_instr !== rdata) begin
                    miscompares++;
                    $display("FAIL %s instr: got %h expected %h", nm, o_instr, rdata);
                end
            end
            bus.imem_ready = (es == ST_FETCH) ? (c == iwait) : 1'($urandom);
            bus.dmem_ready = (es == ST_MEM) ? (c == n - 2) : 1'($urandom);
        end
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        if (!mis) m_pc = tgt;
        end_st = mis ? ST_HALT : ST_FETCH;
        vectors++;
        if (o_state !== end_st || o_pc !== m_pc || o_halted !== mis) begin
            miscompares++;
            $display("FAIL %s end: got state=%0d pc=%h halted=%b expected %0d %h %b",
                     nm, o_state, o_pc, o_halted, end_st, m_pc, mis);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_pc = RESET_PC;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (o_state !== ST_RESET || o_pc !== RESET_PC || o_instr !== 32'h0 || o_halted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_regs: got state=%0d pc=%h instr=%h halted=%b expected 0 %h 0 0",
                     o_state, o_pc, o_instr, o_halted, RESET_PC);
        end
        vectors++;
        if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || o_rf_we !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outs: got imem_req=%b dmem_req=%b rf_we=%b expected 0 0 0",
                     bus.imem_req, bus.dmem_req, o_rf_we);
        end
        bus.imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (o_state !== ST_RESET || bus.imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got state=%0d imem_req=%b expected 0 0", o_state, bus.imem_req);
        end
        bus.imem_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_state !== ST_FETCH || bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL reset_first_fetch: got state=%0d imem_req=%b addr=%h expected 1 1 %h",
                     o_state, bus.imem_req, bus.imem_addr, RESET_PC);
        end
        m_pc = RESET_PC;
    endtask

    task automatic test_basic();
        do_instr(0, 0, 0, 0, 0, 0, 1, 32'h0000_0020, 32'h0, 0, 0, "basic");
    endtask

    task automatic test_branch();
        do_instr(1, 1, 0, 0, 0, 0, 0, 32'd16, 32'h0, 0, 0, "branch_taken");
        do_instr(1, 0, 0, 0, 0, 0, 1, 32'd16, 32'h0, 1, 0, "branch_not_taken");
    endtask

    task automatic test_jalr();
        do_instr(0, 0, 0, 1, 0, 0, 1, 32'd9, 32'h1000_0000, 0, 0, "jalr");
        do_instr(0, 0, 1, 1, 0, 0, 1, 32'd4, 32'h2000_0000, 0, 0, "jalr_over_jump");
    endtask

    task automatic test_jump_wrap();
        do_reset();
        do_instr(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, "wrap_setup");
        do_instr(0, 0, 1, 0, 0, 0, 1, 32'hFFFF_FFF8, 32'h0, 0, 0, "jump_wrap");
    endtask

    task automatic test_load_wait();
        do_instr(0, 0, 0, 0, 1, 0, 1, 32'h40, 32'h0, 0, 3, "load_wait");
    endtask

    task automatic test_store();
        do_instr(0, 0, 0, 0, 0, 1, 1, 32'h40, 32'h0, 0, 1, "store_no_we");
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            do_instr(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                     1'($urandom), 1'($urandom), 1'($urandom),
                     $urandom & ~32'h3, $urandom & ~32'h3,
                     $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_halt();
        do_reset();
        do_instr(0, 0, 1, 0, 0, 0, 1, 32'd6, 32'h0, 0, 0, "halt_misaligned");
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if (o_state !== ST_HALT || o_pc !== RESET_PC || bus.imem_req !== 1'b0 ||
                bus.dmem_req !== 1'b0 || o_rf_we !== 1'b0 || o_halted !== 1'b1) begin
                miscompares++;
                $display("FAIL halt_absorb: got state=%0d pc=%h imem_req=%b dmem_req=%b rf_we=%b halted=%b",
                         o_state, o_pc, bus.imem_req, bus.dmem_req, o_rf_we, o_halted);
            end
        end
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        int we_seen;
        do_reset();
        do_instr(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0, "midmem_setup");
        i_is_load = 1'b1; i_is_store = 1'b0; i_rd_writes = 1'b1;
        i_is_jump = 1'b0; i_is_jalr = 1'b0; i_is_branch = 1'b0; i_immed = 32'h100;
        bus.imem_ready = 1'b1;
        we_seen = 0;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (o_state !== ST_MEM || bus.dmem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL midmem_in_mem: got state=%0d dmem_req=%b expected 4 1", o_state, bus.dmem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.dmem_req !== 1'b0 || o_state !== ST_RESET || o_pc !== RESET_PC) begin
            miscompares++;
            $display("FAIL midmem_async: got dmem_req=%b state=%0d pc=%h expected 0 0 %h",
                     bus.dmem_req, o_state, o_pc, RESET_PC);
        end
        bus.dmem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (o_rf_we !== 1'b0) we_seen++;
        end
        bus.dmem_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        if (o_rf_we !== 1'b0) we_seen++;
        vectors++;
        if (we_seen != 0) begin
            miscompares++;
            $display("FAIL midmem_no_we: got %0d rf_we pulses expected 0", we_seen);
        end
        m_pc = RESET_PC;
        do_instr(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0, "midmem_refetch");
    endtask

    initial begin
        i_is_branch = 0; i_branch_taken = 0; i_is_jump = 0; i_is_jalr = 0;
        i_is_load = 0; i_is_store = 0; i_rd_writes = 0; i_immed = '0; i_rs1_data = '0;
        bus.imem_ready = 1'b0; bus.imem_rdata = '0; bus.dmem_ready = 1'b0;
        m_pc = RESET_PC;
        test_reset();
        test_basic();
        test_branch();
        test_jalr();
        test_jump_wrap();
        test_load_wait();
        test_store();
        test_random();
        test_reset();
        test_halt();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control FSM that owns the program counter register and sequences each instruction through fetch, decode, execute, optional memory access and writeback.
- Drives the instruction-memory and data-memory request handshakes.
- Computes next PC from branch/jump/JALR decode flags.
- Issues the register-file write strobe.
- Sits between the decoder/ALU and the memories; replaces the free-running PC update with a gated, per-instruction update.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
imem_req  output  1  instruction fetch request.
imem_addr  output  32  fetch address; always equals pc.
imem_ready  input  1  instruction-memory response valid.
imem_rdata  input  32  fetched instruction.
instr  output  32  latched current instruction.
is_branch  input  1  decoder: conditional branch.
branch_taken  input  1  ALU compare result.
is_jump  input  1  decoder: JAL.
is_jalr  input  1  decoder: JALR.
is_load  input  1  decoder: load.
is_store  input  1  decoder: store.
rd_writes  input  1  decoder: instruction writes rd.
immed  input  32  sign-extended immediate.
rs1_data  input  32  register rs1 value.
dmem_req  output  1  data-memory request.
dmem_ready  input  1  data-memory response valid.
pc  output  32  current PC.
pc_plus4  output  32  pc+4, used as link value.
rf_we  output  1  register-file write strobe, one cycle.
halted  output  1  sticky misaligned-target halt.
state  output  3  FSM state, for debug.

Behaviour:
- States and encodings: RESET=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6.
- While rst_n is low, all of the following hold immediately (asynchronously), without waiting for clk:
  - state=RESET, pc=RESET_PC, instr=0, next_pc register=0, halted=0.
  - imem_req=0, dmem_req=0, rf_we=0.
- RESET: goes to FETCH on the first clk edge after rst_n is released.
- FETCH:
  - imem_req=1, held until imem_ready.
  - On a clock edge with imem_ready=1: instr<=imem_rdata, state goes to DECODE.
  - If imem_ready is never asserted, FETCH is held indefinitely.
- DECODE: exactly one cycle, then EXECUTE.
- EXECUTE: exactly one cycle. Decode flags are sampled only here. Registers next_pc with priority is_jalr > is_jump > (is_branch & branch_taken):
  - JALR: (rs1_data+immed) & ~32'h1.
  - Jump, or branch taken: pc+immed.
  - Otherwise: pc+4.
  - All sums wrap modulo 2^32; there is no overflow detection.
  - Next state is MEM if is_load|is_store, else WB.
- MEM:
  - dmem_req=1, held until dmem_ready.
  - On a clock edge with dmem_ready=1, state goes to WB.
- WB: exactly one cycle.
  - rf_we=rd_writes & ~is_store.
  - If next_pc[1:0]==0: pc<=next_pc, state goes to FETCH.
  - Otherwise: pc is unchanged, halted<=1, state goes to HALT, and rf_we is suppressed.
- HALT: absorbing state. All request and strobe outputs stay 0 until reset.
- pc changes only on the WB exit edge; it is stable for the whole instruction.
- pc_plus4 is combinational: pc+4.
- Latency with zero-wait memories:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXECUTE, WB).
  - Load or store: 5 cycles.
  - Each imem/dmem wait cycle adds one cycle.
- Reset asserted mid-instruction, including during a pending req: the instruction is abandoned with no rf_we pulse and no PC update; execution restarts at RESET_PC.
- imem_ready/dmem_ready asserted outside their own request state: ignored.

Test Plan:
- Reset release with imem_ready=1 and a non-memory, non-control instruction:
  - pc=0x0 after reset; imem_req rises one cycle after release.
  - pc=0x4 after 4 cycles; rf_we pulses once when rd_writes=1.
- Branch with is_branch=1, branch_taken=1, immed=16, pc=0x4 → pc=0x14 after WB.
- Branch with branch_taken=0, immed=16 → pc=pc+4.
- JALR with rs1_data=0x1000_0000, immed=9 → pc=0x1000_0008 (bit 0 cleared).
- is_jalr=1 and is_jump=1 together → the JALR target wins.
- Jump with immed=-8 (0xFFFF_FFF8) and pc=0x4 → pc=0xFFFF_FFFC (wrap).
- Load with dmem_ready held low 3 cycles → dmem_req stays high 4 cycles; total instruction length 8 cycles; a single rf_we pulse.
- Store with rd_writes=1 → no rf_we.
- Jump with immed=6 from pc=0x0 → halted=1, state=HALT, pc stays 0x0, no further imem_req.
- rst_n pulsed low during MEM with dmem_req=1 → dmem_req drops immediately (asynchronously), pc=RESET_PC, no rf_we pulse; the next fetch is from RESET_PC.
